// File: rtl/lif_pkg.sv
// Shared definitions for the lif_array neuron block: FSM states, default
// parameter values and the saturating adder used by the update datapath.
package lif_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    localparam int LIF_N_CH       = 4;
    localparam int LIF_W          = 8;
    localparam int LIF_LEAK_SHIFT = 1;
    localparam int LIF_REFRAC     = 2;

    // Unsigned add clamped to 2^w-1 (w <= 31); callers truncate to their width.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << w) - 33'd1;
        return (sum > lim) ? lim[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-channel leaky integrate-and-fire update.
// Refractory hold is compiled in only with LIF_REFRACTORY_EN defined.
module lif_update
    import lif_pkg::*;
#(
    parameter int W          = LIF_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC     = LIF_REFRAC,
    parameter int CW         = 2
`endif
) (
    input  logic [W-1:0]  v,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  thr,
`ifdef LIF_REFRACTORY_EN
    input  logic [CW-1:0] cnt,
    output logic [CW-1:0] next_cnt,
`endif
    output logic [W-1:0]  next_v,
    output logic          fire
);

    logic [W-1:0] leak;

    always_comb begin
        fire   = (v >= thr);
        leak   = fire ? '0 : (v >> LEAK_SHIFT);
        next_v = W'(sat_add(32'(c), 32'(leak), W));
`ifdef LIF_REFRACTORY_EN
        next_cnt = fire ? CW'(REFRAC) : '0;
        // A held channel ignores its input and stays silent.
        if (cnt != '0) begin
            fire     = 1'b0;
            next_v   = '0;
            next_cnt = cnt - 1'b1;
        end
`endif
    end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array: one shared update path, one channel per clock.
// Optional refractory hold via LIF_REFRACTORY_EN.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_CH       = LIF_N_CH,
    parameter int W          = LIF_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int REFRAC     = LIF_REFRAC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick,
    input  logic [N_CH*W-1:0]         cur_bus,
    input  logic [W-1:0]              thr,
    input  logic [$clog2(N_CH)-1:0]   rd_ch,
    output logic [W-1:0]              v_out,
    output logic [N_CH-1:0]           spk_out,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);

    localparam int CHW = $clog2(N_CH);

    if (N_CH < 2 || REFRAC < 0) begin : g_bad_params
        $error("lif_array: N_CH must be >= 2 and REFRAC >= 0");
    end

    state_t              state;
    logic [CHW-1:0]      ch;
    logic [N_CH*W-1:0]   cur_lat;
    logic [W-1:0]        thr_lat;
    logic [W-1:0]        mem [N_CH];
    logic [N_CH-1:0]     spk_acc;
    logic [N_CH-1:0]     spk_next;
    logic [W-1:0]        cur_sel;
    logic [W-1:0]        next_v;
    logic                fire;

    assign cur_sel = cur_lat[int'(ch)*W +: W];
    assign v_out   = mem[rd_ch];

`ifdef LIF_REFRACTORY_EN
    localparam int CW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [CW-1:0] rc [N_CH];
    logic [CW-1:0] next_cnt;

    lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT),
        .REFRAC     (REFRAC),
        .CW         (CW)
    ) u_update (
        .v        (mem[ch]),
        .c        (cur_sel),
        .thr      (thr_lat),
        .cnt      (rc[ch]),
        .next_cnt (next_cnt),
        .next_v   (next_v),
        .fire     (fire)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) rc[i] <= '0;
        end else if (state == ST_SWEEP) begin
            rc[ch] <= next_cnt;
        end
    end
`else
    lif_update #(
        .W          (W),
        .LEAK_SHIFT (LEAK_SHIFT)
    ) u_update (
        .v      (mem[ch]),
        .c      (cur_sel),
        .thr    (thr_lat),
        .next_v (next_v),
        .fire   (fire)
    );
`endif

    always_comb begin
        spk_next     = spk_acc;
        spk_next[ch] = fire;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ch      <= '0;
            cur_lat <= '0;
            thr_lat <= '0;
            spk_acc <= '0;
            spk_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int i = 0; i < N_CH; i++) mem[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (tick) begin
                        cur_lat <= cur_bus;
                        thr_lat <= thr;
                        ch      <= '0;
                        spk_acc <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SWEEP;
                    end
                end
                ST_SWEEP: begin
                    if (tick) overrun <= 1'b1;
                    mem[ch] <= next_v;
                    spk_acc <= spk_next;
                    if (ch == CHW'(N_CH - 1)) begin
                        spk_out <= spk_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        ch      <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// Randomized and directed bench for lif_array against a sweep-level model.
// Model follows LIF_REFRACTORY_EN when the bench is built with it.
module tb_lif_array;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int LS   = 1;
    localparam int RF   = 2;
    localparam int VMAX = (1 << W) - 1;
`ifdef LIF_REFRACTORY_EN
    localparam bit REFR_EN = (RF > 0);
`else
    localparam bit REFR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset_n;
    logic           tick;
    logic [N*W-1:0] cur_bus;
    logic [W-1:0]   thr;
    logic [1:0]     rd_ch;
    logic [W-1:0]   v_out;
    logic [N-1:0]   spk_out;
    logic           busy;
    logic           done;
    logic           overrun;

    int checks = 0;
    int errors = 0;

    int mv [N];
    int rc [N];
    int m_spk;
    int m_ovr;

    always #5 clk = ~clk;

    lif_array #(
        .N_CH       (N),
        .W          (W),
        .LEAK_SHIFT (LS),
        .REFRAC     (RF)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .cur_bus (cur_bus),
        .thr     (thr),
        .rd_ch   (rd_ch),
        .v_out   (v_out),
        .spk_out (spk_out),
        .busy    (busy),
        .done    (done),
        .overrun (overrun)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
            rc[i] = 0;
        end
        m_spk = 0;
        m_ovr = 0;
    endtask

    // One full sweep of the neuron equations, spikes taken from pre-update state.
    task automatic model_sweep(input int cur [N], input int th);
        int s;
        bit f;
        m_spk = 0;
        for (int i = 0; i < N; i++) begin
            if (rc[i] > 0) begin
                mv[i] = 0;
                rc[i] = rc[i] - 1;
            end else begin
                f = (mv[i] >= th);
                if (f) m_spk = m_spk | (1 << i);
                s = cur[i] + (f ? 0 : (mv[i] >> LS));
                mv[i] = (s > VMAX) ? VMAX : s;
                if (f && REFR_EN) rc[i] = RF;
            end
        end
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_ch = 2'(i);
            #1;
            check(tag, v_out, mv[i]);
        end
    endtask

    function automatic int read_v(input int i);
        return mv[i];
    endfunction

    task automatic do_sweep(input int cur [N], input int th,
                            input int gap, input bit poke);
        repeat (gap) step();
        for (int i = 0; i < N; i++) cur_bus[i*W +: W] = W'(cur[i]);
        thr  = W'(th);
        tick = 1'b1;
        step();
        tick = 1'b0;
        cur_bus = $urandom;
        thr     = W'($urandom);
        check("busy_start", busy, 1);
        check("done_start", done, 0);
        for (int i = 1; i <= N; i++) begin
            if (poke && i == 2) tick = 1'b1;
            step();
            tick = 1'b0;
            if (i < N) check("done_early", done, 0);
        end
        model_sweep(cur, th);
        if (poke) m_ovr = 1;
        check("done_end", done, 1);
        check("busy_end", busy, 0);
        check("spk_out", spk_out, m_spk);
        check("overrun", overrun, m_ovr);
        read_all("v_out");
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick    = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        model_reset();
        check("rst_spk", spk_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovr", overrun, 0);
        read_all("rst_v");
    endtask

    initial begin
        int c [N];
        reset_n = 1'b0;
        tick    = 1'b0;
        cur_bus = '0;
        thr     = '0;
        rd_ch   = '0;
        model_reset();

        do_reset();

        // leak and fire on channel 0
        c = '{6, 0, 0, 0};
        do_sweep(c, 8, 0, 1'b0);
        check("leak_s1", read_v(0), 6);
        do_sweep(c, 8, 0, 1'b0);
        check("leak_s2", read_v(0), 9);
        do_sweep(c, 8, 0, 1'b0);
`ifndef LIF_REFRACTORY_EN
        check("leak_fire", spk_out[0], 1);
        check("leak_s3", read_v(0), 6);
`endif
        do_reset();
        c = '{4, 0, 0, 0};
        repeat (5) do_sweep(c, 8, 0, 1'b0);
        check("leak_nofire", spk_out[0], 0);
        check("leak_settle", read_v(0), 7);

        // saturation on channel 1
        do_reset();
        c = '{0, 200, 0, 0};
        do_sweep(c, 255, 0, 1'b0);
        do_sweep(c, 255, 0, 1'b0);
        check("sat_v1", read_v(1), 255);
        check("sat_nofire", spk_out[1], 0);
        do_sweep(c, 255, 0, 1'b0);
        check("sat_fire", spk_out[1], 1);

        // overrun, sticky across later sweeps
        do_reset();
        c = '{1, 2, 3, 4};
        do_sweep(c, 8, 1, 1'b1);
        do_sweep(c, 8, 0, 1'b0);
        check("ovr_sticky", overrun, 1);

        // refractory channel 2, and thr=0 firing everything
        do_reset();
        c = '{0, 0, 15, 0};
        repeat (5) do_sweep(c, 8, 0, 1'b0);
        do_sweep(c, 0, 2, 1'b0);
        check("thr0_all", spk_out, 4'hf);

        // reset mid-sweep
        c = '{9, 9, 9, 9};
        for (int i = 0; i < N; i++) cur_bus[i*W +: W] = W'(c[i]);
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        model_reset();
        check("mid_busy", busy, 0);
        check("mid_spk", spk_out, 0);
        check("mid_ovr", overrun, 0);
        read_all("mid_v");
        repeat (3) begin
            step();
            check("mid_nodone", done, 0);
        end
        do_sweep(c, 8, 0, 1'b0);

        // randomized sweeps
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++)
                c[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, VMAX)
                                                   : $urandom_range(0, 20);
            do_sweep(c,
                     ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40),
                     $urandom_range(0, 2),
                     ($urandom_range(0, 4) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
